// File: rtl/harness_pkg.sv
// Shared types and constants for the program-load / run / dump harness.
package harness_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned REG_AW   = 5;

  typedef enum logic [2:0] {
    HS_LOAD  = 3'd0,
    HS_ARMED = 3'd1,
    HS_RUN   = 3'd2,
    HS_DUMP  = 3'd3,
    HS_DONE  = 3'd4
  } hs_state_t;

endpackage

// File: rtl/boot_harness.sv
// Program-load and run controller: streams a program into IMEM while the core
// is held in reset, runs the core for a fixed cycle count, then freezes it and
// dumps selected register-file entries as a result stream.
module boot_harness
  import harness_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned NUM_SNAP   = 4,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned IMEM_AW   = $clog2(IMEM_DEPTH),
  localparam int unsigned SIDX_W    = (NUM_SNAP > 1) ? $clog2(NUM_SNAP) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [XLEN-1:0]            load_data,
  input  logic                       load_last,
  input  logic                       start,
  input  logic [CNT_W-1:0]           run_cycles,
  input  logic [NUM_SNAP*REG_AW-1:0] snap_addr,
  output logic                       imem_we,
  output logic [IMEM_AW-1:0]         imem_addr,
  output logic [XLEN-1:0]            imem_wdata,
  output logic                       cpu_rst,
  output logic                       cpu_en,
  output logic [REG_AW-1:0]          rf_raddr,
  input  logic [XLEN-1:0]            rf_rdata,
  output logic                       snap_valid,
  output logic [SIDX_W-1:0]          snap_idx,
  output logic [XLEN-1:0]            snap_data,
  output logic [CNT_W-1:0]           cycle_count,
  output logic                       done,
  output logic                       err_trunc
);

  hs_state_t          r_state;
  hs_state_t          w_next;
  logic [IMEM_AW-1:0] r_wr_ptr;
  logic [CNT_W-1:0]   r_run_cnt;
  logic [CNT_W-1:0]   r_cycle_count;
  logic [SIDX_W-1:0]  r_dump_idx;
  logic               r_load_ready;
  logic               r_cpu_rst;
  logic               r_cpu_en;
  logic               r_done;
  logic               r_err_trunc;
  logic               r_imem_we;
  logic [IMEM_AW-1:0] r_imem_addr;
  logic [XLEN-1:0]    r_imem_wdata;
  logic               r_snap_valid;
  logic [SIDX_W-1:0]  r_snap_idx;
  logic [XLEN-1:0]    r_snap_data;
  logic [REG_AW-1:0]  w_rf_raddr;
  logic               w_hs;
  logic               w_ptr_end;
  logic               w_dump_act;
  logic               w_dump_last;

  // load_ready is registered from the next state, so it is high exactly in LOAD
  assign w_hs        = load_valid & r_load_ready & ~clear;
  assign w_ptr_end   = (r_wr_ptr == IMEM_AW'(IMEM_DEPTH - 1));
  assign w_dump_act  = (r_state == HS_DUMP) & ~clear;
  assign w_dump_last = (r_dump_idx == SIDX_W'(NUM_SNAP - 1));

  // Next-state decode; clear overrides every transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      HS_LOAD:  if (w_hs && (load_last || w_ptr_end)) w_next = HS_ARMED;
      HS_ARMED: if (start) w_next = (run_cycles == '0) ? HS_DUMP : HS_RUN;
      HS_RUN:   if (r_run_cnt == CNT_W'(1)) w_next = HS_DUMP;
      HS_DUMP:  if (w_dump_last) w_next = HS_DONE;
      HS_DONE:  if (start) w_next = HS_ARMED;
      default:  w_next = HS_LOAD;
    endcase
    if (clear) w_next = HS_LOAD;
  end

  // Debug read address selects the snap entry for the current dump index
  always_comb begin
    w_rf_raddr = '0;
    if (r_state == HS_DUMP) begin
      for (int unsigned i = 0; i < NUM_SNAP; i++) begin
        if (r_dump_idx == SIDX_W'(i)) w_rf_raddr = snap_addr[REG_AW*i +: REG_AW];
      end
    end
  end

  // FSM state and state-derived control outputs (registered from next state)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= HS_LOAD;
      r_load_ready <= 1'b1;
      r_cpu_rst    <= 1'b1;
      r_cpu_en     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_load_ready <= (w_next == HS_LOAD);
      r_cpu_rst    <= (w_next == HS_LOAD) || (w_next == HS_ARMED);
      r_cpu_en     <= (w_next == HS_RUN);
      r_done       <= (w_next == HS_DONE);
    end
  end

  // Program load: write pointer, IMEM write port and truncation flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_err_trunc  <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
    end else begin
      r_imem_we <= w_hs;
      if (w_hs) begin
        r_imem_addr  <= r_wr_ptr;
        r_imem_wdata <= load_data;
      end
      if (clear) begin
        r_wr_ptr    <= '0;
        r_err_trunc <= 1'b0;
      end else if (w_hs) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_ptr_end && !load_last) r_err_trunc <= 1'b1;
      end
    end
  end

  // Run-length down-counter and run-cycle up-counter; cycle_count survives clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run_cnt     <= '0;
      r_cycle_count <= '0;
    end else if (!clear) begin
      if (r_state == HS_ARMED && start) begin
        r_run_cnt     <= run_cycles;
        r_cycle_count <= '0;
      end else if (r_state == HS_RUN) begin
        r_run_cnt     <= r_run_cnt - 1'b1;
        r_cycle_count <= r_cycle_count + 1'b1;
      end
    end
  end

  // Dump sequencing: one register-file entry captured per DUMP cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dump_idx   <= '0;
      r_snap_valid <= 1'b0;
      r_snap_idx   <= '0;
      r_snap_data  <= '0;
    end else begin
      r_dump_idx   <= (w_dump_act && !w_dump_last) ? r_dump_idx + 1'b1 : '0;
      r_snap_valid <= w_dump_act;
      if (w_dump_act) begin
        r_snap_idx  <= r_dump_idx;
        r_snap_data <= rf_rdata;
      end
    end
  end

  assign load_ready  = r_load_ready;
  assign imem_we     = r_imem_we;
  assign imem_addr   = r_imem_addr;
  assign imem_wdata  = r_imem_wdata;
  assign cpu_rst     = r_cpu_rst;
  assign cpu_en      = r_cpu_en;
  assign rf_raddr    = w_rf_raddr;
  assign snap_valid  = r_snap_valid;
  assign snap_idx    = r_snap_idx;
  assign snap_data   = r_snap_data;
  assign cycle_count = r_cycle_count;
  assign done        = r_done;
  assign err_trunc   = r_err_trunc;

endmodule

// File: tb/tb_boot_harness.sv
// Directed bench for boot_harness: load/run/dump flow, truncation on a small
// IMEM, zero-length run, rerun, clear, throttled load and reset mid-run.
module tb_boot_harness;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // main instance (IMEM_DEPTH 256)
  logic        clear = 0, load_valid = 0, load_last = 0, start = 0;
  logic [31:0] load_data = '0, run_cycles = '0;
  logic [19:0] snap_addr = '0;
  logic        load_ready, imem_we, cpu_rst, cpu_en, snap_valid, done, err_trunc;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata, rf_rdata, snap_data, cycle_count;
  logic [4:0]  rf_raddr;
  logic [1:0]  snap_idx;

  // small instance (IMEM_DEPTH 4)
  logic        s_clear = 0, s_load_valid = 0, s_load_last = 0, s_start = 0;
  logic [31:0] s_load_data = '0, s_run_cycles = '0;
  logic [19:0] s_snap_addr = '0;
  logic        s_load_ready, s_imem_we, s_cpu_rst, s_cpu_en, s_snap_valid, s_done, s_err_trunc;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wdata, s_rf_rdata, s_snap_data, s_cycle_count;
  logic [4:0]  s_rf_raddr;
  logic [1:0]  s_snap_idx;

  // register-file stand-in: x1=5, x2=10, x5=15 as left by the test program
  logic [31:0] regs [32];
  assign rf_rdata   = regs[rf_raddr];
  assign s_rf_rdata = regs[s_rf_raddr];

  boot_harness #(.XLEN(32), .IMEM_DEPTH(256), .NUM_SNAP(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .start(start), .run_cycles(run_cycles),
    .snap_addr(snap_addr), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .snap_valid(snap_valid), .snap_idx(snap_idx), .snap_data(snap_data),
    .cycle_count(cycle_count), .done(done), .err_trunc(err_trunc));

  boot_harness #(.XLEN(32), .IMEM_DEPTH(4), .NUM_SNAP(4), .CNT_W(32)) u_small (
    .clk(clk), .rst(rst), .clear(s_clear), .load_valid(s_load_valid), .load_ready(s_load_ready),
    .load_data(s_load_data), .load_last(s_load_last), .start(s_start), .run_cycles(s_run_cycles),
    .snap_addr(s_snap_addr), .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
    .cpu_rst(s_cpu_rst), .cpu_en(s_cpu_en), .rf_raddr(s_rf_raddr), .rf_rdata(s_rf_rdata),
    .snap_valid(s_snap_valid), .snap_idx(s_snap_idx), .snap_data(s_snap_data),
    .cycle_count(s_cycle_count), .done(s_done), .err_trunc(s_err_trunc));

  int total = 0;
  int bad   = 0;

  logic [31:0] prog [3];
  logic [31:0] exp_snap [4];
  logic [31:0] tb_imem [256];
  logic [7:0]  wr_addr [16];
  logic [31:0] wr_data [16];
  logic [31:0] snap_d [8];
  logic [1:0]  snap_i [8];
  int wr_n = 0, snap_n = 0, en_n = 0, s_wr_n = 0;
  logic [1:0]  s_last_addr;
  logic [31:0] s_last_data;

  // observers sample on the falling edge, away from register updates
  always @(negedge clk) begin
    if (imem_we) begin
      tb_imem[imem_addr] = imem_wdata;
      if (wr_n < 16) begin
        wr_addr[wr_n] = imem_addr;
        wr_data[wr_n] = imem_wdata;
      end
      wr_n++;
    end
    if (snap_valid) begin
      if (snap_n < 8) begin
        snap_d[snap_n] = snap_data;
        snap_i[snap_n] = snap_idx;
      end
      snap_n++;
    end
    if (cpu_en) en_n++;
    if (s_imem_we) begin
      s_last_addr = s_imem_addr;
      s_last_data = s_imem_wdata;
      s_wr_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start(input logic [31:0] rc);
    snap_n = 0;
    en_n = 0;
    run_cycles = rc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
    total++;
    if (cpu_rst !== 1'b1) begin bad++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
    total++;
    if ({imem_we, imem_addr, imem_wdata, cpu_en, rf_raddr, snap_valid, snap_idx, snap_data,
         cycle_count, done, err_trunc} !== '0) begin
      bad++;
      $display("FAIL reset_zero_outputs: got we=%b a=%0h d=%0h en=%b ra=%0h sv=%b si=%0h sd=%0h cc=%0h dn=%b et=%b want all 0",
               imem_we, imem_addr, imem_wdata, cpu_en, rf_raddr, snap_valid, snap_idx, snap_data,
               cycle_count, done, err_trunc);
    end
    total++;
    if ({s_load_ready, s_cpu_rst, s_err_trunc} !== 3'b110) begin
      bad++; $display("FAIL reset_small: got %b want 110", {s_load_ready, s_cpu_rst, s_err_trunc});
    end
    #2 rst = 1'b1;
  endtask

  task automatic test_trunc();
    s_wr_n = 0;
    tick();
    s_load_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_load_data = 32'hA000_0000 + i;
      tick();
    end
    s_load_valid = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (s_wr_n !== 4) begin bad++; $display("FAIL trunc_write_count: got %0d want 4", s_wr_n); end
    total++;
    if (s_load_ready !== 1'b0) begin bad++; $display("FAIL trunc_load_ready: got %b want 0", s_load_ready); end
    total++;
    if (s_err_trunc !== 1'b1) begin bad++; $display("FAIL trunc_err: got %b want 1", s_err_trunc); end
    total++;
    if (s_last_addr !== 2'd3 || s_last_data !== 32'hA000_0003) begin
      bad++; $display("FAIL trunc_last_write: got a=%0d d=%h want a=3 d=a0000003", s_last_addr, s_last_data);
    end
  endtask

  task automatic test_load_run();
    bit ok;
    wr_n = 0;
    for (int k = 0; k < 3; k++) begin
      load_valid = 1'b1;
      load_data  = prog[k];
      load_last  = (k == 2);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    total++;
    if (load_ready !== 1'b0) begin bad++; $display("FAIL load_ready_drop: got %b want 0", load_ready); end
    total++;
    if (imem_we !== 1'b1 || imem_addr !== 8'd2 || imem_wdata !== 32'h001102B3) begin
      bad++; $display("FAIL final_write_in_armed: got we=%b a=%0d d=%h want we=1 a=2 d=001102b3",
                      imem_we, imem_addr, imem_wdata);
    end
    tick();
    total++;
    if (imem_we !== 1'b0 || cpu_rst !== 1'b1) begin
      bad++; $display("FAIL armed_idle: got we=%b cpu_rst=%b want we=0 cpu_rst=1", imem_we, cpu_rst);
    end
    total++;
    if (wr_n !== 3) begin bad++; $display("FAIL load_write_count: got %0d want 3", wr_n); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== prog[i]) begin
        bad++; $display("FAIL load_write_%0d: got a=%0d d=%h want a=%0d d=%h", i, wr_addr[i], wr_data[i], i, prog[i]);
      end
    end
    total++;
    if (err_trunc !== 1'b0) begin bad++; $display("FAIL no_trunc: got %b want 0", err_trunc); end
    pulse_start(32'd10);
    total++;
    if (cpu_rst !== 1'b0 || cpu_en !== 1'b1) begin
      bad++; $display("FAIL run_entry: got cpu_rst=%b cpu_en=%b want 0 1", cpu_rst, cpu_en);
    end
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL run_done_timeout: got done=0 want done=1 within 200 cycles"); end
    total++;
    if (snap_valid !== 1'b1 || snap_idx !== 2'd3) begin
      bad++; $display("FAIL last_snap_with_done: got sv=%b idx=%0d want sv=1 idx=3", snap_valid, snap_idx);
    end
    tick();
    tick();
    @(negedge clk);
    total++;
    if (snap_n !== 4) begin bad++; $display("FAIL snap_count: got %0d want 4", snap_n); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (snap_i[i] !== 2'(i) || snap_d[i] !== exp_snap[i]) begin
        bad++; $display("FAIL snap_%0d: got idx=%0d data=%0d want idx=%0d data=%0d", i, snap_i[i], snap_d[i], i, exp_snap[i]);
      end
    end
    total++;
    if (cycle_count !== 32'd10 || en_n !== 10) begin
      bad++; $display("FAIL run_length: got cycle_count=%0d en_cycles=%0d want 10 10", cycle_count, en_n);
    end
    total++;
    if (done !== 1'b1 || cpu_en !== 1'b0 || cpu_rst !== 1'b0) begin
      bad++; $display("FAIL done_level: got done=%b en=%b rst=%b want 1 0 0", done, cpu_en, cpu_rst);
    end
  endtask

  task automatic test_rerun();
    bit ok;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (cpu_rst !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL done_to_armed: got cpu_rst=%b done=%b want 1 0", cpu_rst, done);
    end
    tick();
    pulse_start(32'd10);
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rerun_done_timeout: got done=0 want done=1 within 200 cycles"); end
    tick();
    @(negedge clk);
    total++;
    if (snap_n !== 4) begin bad++; $display("FAIL rerun_snap_count: got %0d want 4", snap_n); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (snap_d[i] !== exp_snap[i]) begin
        bad++; $display("FAIL rerun_snap_%0d: got %0d want %0d", i, snap_d[i], exp_snap[i]);
      end
    end
    total++;
    if (cycle_count !== 32'd10) begin bad++; $display("FAIL rerun_cycle_count: got %0d want 10", cycle_count); end
  endtask

  task automatic test_clear();
    tick();
    start = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    total++;
    if (load_ready !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1) begin
      bad++; $display("FAIL clear_to_load: got ready=%b done=%b cpu_rst=%b want 1 0 1", load_ready, done, cpu_rst);
    end
    total++;
    if (cycle_count !== 32'd10) begin bad++; $display("FAIL clear_keeps_count: got %0d want 10", cycle_count); end
  endtask

  task automatic test_random_valid();
    int k;
    for (int i = 0; i < 3; i++) tb_imem[i] = 32'h0;
    wr_n = 0;
    k = 0;
    for (int c = 0; c < 80 && k < 3; c++) begin
      load_valid = (c >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
      load_data  = load_valid ? prog[k] : 32'hBAD0_0000 + c;
      load_last  = (k == 2);
      if (load_valid && load_ready) k++;
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (k !== 3 || wr_n !== 3) begin bad++; $display("FAIL rand_load_count: got hs=%0d writes=%0d want 3 3", k, wr_n); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (tb_imem[i] !== prog[i]) begin
        bad++; $display("FAIL rand_imem_%0d: got %h want %h", i, tb_imem[i], prog[i]);
      end
    end
    total++;
    if (load_ready !== 1'b0 || err_trunc !== 1'b0) begin
      bad++; $display("FAIL rand_armed: got ready=%b err=%b want 0 0", load_ready, err_trunc);
    end
  endtask

  task automatic test_zero_run();
    bit ok;
    tick();
    pulse_start(32'd0);
    total++;
    if (cpu_rst !== 1'b0 || cpu_en !== 1'b0) begin
      bad++; $display("FAIL zero_run_entry: got cpu_rst=%b cpu_en=%b want 0 0", cpu_rst, cpu_en);
    end
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL zero_done_timeout: got done=0 want done=1 within 200 cycles"); end
    tick();
    @(negedge clk);
    total++;
    if (en_n !== 0 || cycle_count !== 32'd0) begin
      bad++; $display("FAIL zero_run_len: got en_cycles=%0d cycle_count=%0d want 0 0", en_n, cycle_count);
    end
    total++;
    if (snap_n !== 4) begin bad++; $display("FAIL zero_snap_count: got %0d want 4", snap_n); end
  endtask

  task automatic test_reset_midrun();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    pulse_start(32'd10);
    tick();
    tick();
    total++;
    if (cpu_en !== 1'b1) begin bad++; $display("FAIL midrun_running: got cpu_en=%b want 1", cpu_en); end
    rst = 1'b0;
    #1;
    total++;
    if (cpu_rst !== 1'b1 || cpu_en !== 1'b0 || load_ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL midrun_reset: got rst=%b en=%b ready=%b done=%b want 1 0 1 0",
                      cpu_rst, cpu_en, load_ready, done);
    end
    total++;
    if (cycle_count !== 32'd0) begin bad++; $display("FAIL midrun_count_reset: got %0d want 0", cycle_count); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hDEAD_0000 + i;
    regs[0] = 32'd0;
    regs[1] = 32'd5;
    regs[2] = 32'd10;
    regs[5] = 32'd15;
    prog[0] = 32'h00500093;
    prog[1] = 32'h00108133;
    prog[2] = 32'h001102B3;
    exp_snap[0] = 32'd5;
    exp_snap[1] = 32'd10;
    exp_snap[2] = 32'd15;
    exp_snap[3] = 32'd0;
    snap_addr   = {5'd0, 5'd5, 5'd2, 5'd1};
    s_snap_addr = {5'd0, 5'd5, 5'd2, 5'd1};

    test_reset();
    test_trunc();
    test_load_run();
    test_rerun();
    test_clear();
    test_random_valid();
    test_zero_run();
    test_reset_midrun();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion want completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/boot_harness.md
# boot_harness

Synthesizable program-load and run controller for the 5-stage RISC-V pipeline `top`. It streams a program into instruction memory while holding the core in reset, then releases the core for a programmable number of cycles. It then freezes the core and dumps a configurable set of register-file entries as a result stream. It replaces hierarchical preload and snapshot pokes with a reusable block that works in simulation and on FPGA.

## Interface
- `XLEN`, 32, data and instruction word width
- `IMEM_DEPTH`, 256, instruction memory depth in words; `IMEM_AW = $clog2(IMEM_DEPTH)`
- `NUM_SNAP`, 4, number of register-file entries dumped after a run
- `CNT_W`, 32, width of the run-length and cycle counters

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous return to LOAD from any state
- `load_valid`  in  1  program word valid
- `load_ready`  out  1  block accepts a program word
- `load_data`  in  XLEN  instruction word
- `load_last`  in  1  marks the final program word
- `start`  in  1  single-cycle run request
- `run_cycles`  in  CNT_W  core run length, sampled when `start` is accepted
- `snap_addr`  in  NUM_SNAP*5  register indices to dump; entry i is bits [5i+4:5i]
- `imem_we`, `imem_addr[IMEM_AW]`, `imem_wdata[XLEN]`  out  instruction memory write port
- `cpu_rst`  out  1  active-high core reset
- `cpu_en`  out  1  core pipeline enable; 0 stalls all pipeline registers and the PC
- `rf_raddr`  out  5  register-file debug read address (combinational read)
- `rf_rdata`  in  XLEN  register-file debug read data
- `snap_valid`, `snap_idx[$clog2(NUM_SNAP)]`, `snap_data[XLEN]`  out  dump stream
- `cycle_count`  out  CNT_W  number of cycles spent in RUN during the last run
- `done`  out  1  dump complete (level)
- `err_trunc`  out  1  program filled IMEM before `load_last` (sticky)

## Operation
- States: LOAD, ARMED, RUN, DUMP, DONE. Reset state is LOAD.
- LOAD:
  - `load_ready`=1 and `cpu_rst`=1.
  - A handshake (`load_valid & load_ready`) writes `load_data` at `wr_ptr`, then `wr_ptr` increments.
  - A handshake with `load_last`, or a handshake at `wr_ptr == IMEM_DEPTH-1`, moves to ARMED.
  - If the second condition holds without `load_last`, set `err_trunc`.
- ARMED:
  - `cpu_rst`=1.
  - `start` loads `run_cnt = run_cycles`, clears `cycle_count`, and moves to RUN.
  - If `run_cycles == 0`, it moves to DUMP instead and the core never runs.
- RUN:
  - `cpu_rst`=0 and `cpu_en`=1.
  - `run_cnt` decrements and `cycle_count` increments each cycle.
  - When `run_cnt == 1`, move to DUMP. The core therefore runs exactly `run_cycles` cycles.
- DUMP:
  - `cpu_rst`=0 and `cpu_en`=0, so the core is frozen and its state preserved.
  - `dump_idx` counts 0..NUM_SNAP-1, with `rf_raddr = snap_addr[dump_idx]`.
  - Each cycle registers `snap_data <= rf_rdata`, `snap_idx <= dump_idx`, `snap_valid <= 1`.
  - After `dump_idx == NUM_SNAP-1`, move to DONE.
- DONE:
  - `done`=1 and `cpu_en`=0.
  - `start` moves to ARMED, which re-asserts `cpu_rst`. The program is retained; a second `start` reruns it.
- `clear` has priority over every transition:
  - Next state is LOAD.
  - `wr_ptr`, `err_trunc` and `done` are zeroed.
  - `cycle_count` is retained.
- Counters wrap modulo 2^CNT_W. No saturation is required.

## Timing
- Reset values:
  - `load_ready`=1, `cpu_rst`=1.
  - All other outputs are 0: `imem_we`, `imem_addr`, `imem_wdata`, `cpu_en`, `rf_raddr`, `snap_valid`, `snap_idx`, `snap_data`, `cycle_count`, `done`, `err_trunc`.
- Every output is registered except `rf_raddr`, which is decoded from `dump_idx`.
- IMEM write latency is 1: `imem_we` is high for one cycle after each handshake, with that handshake's address and data. The final write lands in the first ARMED cycle.
- `load_ready` drops the cycle after the final handshake.
- `start` accepted in ARMED puts `cpu_rst` low on the next cycle.
- The first `snap_valid` occurs one cycle after entering DUMP. There are exactly NUM_SNAP consecutive `snap_valid` cycles.
- The last `snap_valid` coincides with the first cycle of `done`.
- `start` is ignored outside ARMED and DONE. `load_valid` is ignored outside LOAD.
- Asserting `rst` mid-operation:
  - Immediately forces LOAD and the reset output values, including `cpu_rst`=1.
  - IMEM contents are untouched.

## Structure
- `harness_pkg`: state enum `hs_state_t`, `XLEN` default, and the register-index width constant 5.
- Single module. No sub-module is warranted; the FSM, two counters and the dump index are sufficient.

## Test plan
- Load 00500093, 00108133, 001102B3 (`load_last` on the third word), `snap_addr`={0,5,2,1}, `run_cycles`=10, `start` → `imem_we` pulses at addresses 0..2. Snaps are idx0=5, idx1=10, idx2=15, idx3=0. `cycle_count`=10.
- `IMEM_DEPTH`=4, stream 6 words without `load_last` → 4 words written, `load_ready`=0 after the 4th, `err_trunc`=1.
- `run_cycles`=0 → `cpu_en` never 1, `cycle_count`=0, the dump still produces NUM_SNAP beats.
- `rst` asserted at RUN cycle 3 → `cpu_rst`=1, `cpu_en`=0 and state LOAD in the same cycle; `done`=0.
- In DONE, `start`, `start` → rerun with identical snaps. `clear` → `load_ready`=1, `done`=0.
- `load_valid` toggling randomly with a 3-word program → the same IMEM image results.
